// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND scan/convert path.
package fnd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 4;
  localparam int MAX_VALUE  = 9999;
  localparam int BIN_W      = 14;
  localparam int ITER       = BIN_W;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// Load/status and digit-drive bundle between the calculator top and fnd_scan_ctrl.
interface fnd_scan_ctrl_if;
  import fnd_pkg::*;

  logic [BIN_W-1:0] i_value;
  logic             i_load;
  logic             o_busy;
  logic             o_overflow;
  logic [1:0]       o_digitSelect;
  logic [3:0]       o_bcd;
  logic             o_en;

  modport master (
    output i_value, i_load,
    input  o_busy, o_overflow, o_digitSelect, o_bcd, o_en
  );

  modport slave (
    input  i_value, i_load,
    output o_busy, o_overflow, o_digitSelect, o_bcd, o_en
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: saturates the input to 9999, then runs 14 adjust+shift
// iterations and presents the 16-bit BCD result for one COMMIT cycle.
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [BCD_W-1:0] result
);

  localparam int SHIFT_W = BCD_W + BIN_W;
  localparam int CNT_W   = $clog2(ITER);

  state_t             state_r, state_s;
  logic [SHIFT_W-1:0] shift_r, shift_s, adj_s;
  logic [CNT_W-1:0]   iter_r, iter_s;
  logic               busy_r, done_r, ovf_r, ovf_s;
  logic               over_s;
  logic [BIN_W-1:0]   sat_s;

  always_comb begin
    over_s = (value > BIN_W'(MAX_VALUE));
    if (over_s) begin
      sat_s = BIN_W'(MAX_VALUE);
    end else begin
      sat_s = value;
    end
  end

  // Next-state and datapath; the nibble adjust precedes the shift in the same cycle.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    iter_s  = iter_r;
    ovf_s   = ovf_r;
    adj_s   = {bcd_adjust(shift_r[SHIFT_W-1 -: BCD_W]), shift_r[BIN_W-1:0]};
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = CONVERT;
          shift_s = {{BCD_W{1'b0}}, sat_s};
          iter_s  = {CNT_W{1'b0}};
          ovf_s   = over_s;
        end else begin
          state_s = IDLE;
        end
      end
      CONVERT: begin
        shift_s = adj_s << 1;
        if (iter_r == CNT_W'(ITER - 1)) begin
          state_s = COMMIT;
          iter_s  = {CNT_W{1'b0}};
        end else begin
          iter_s  = iter_r + CNT_W'(1);
        end
      end
      COMMIT: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and flag registers; busy/done are derived from the next state so they are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      shift_r <= {SHIFT_W{1'b0}};
      iter_r  <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      iter_r  <= iter_s;
      ovf_r   <= ovf_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == COMMIT);
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign overflow = ovf_r;
  assign result   = shift_r[SHIFT_W-1 -: BCD_W];

endmodule

// File: rtl/fnd_scan_ctrl.sv
// 4-digit FND front end: binary-to-BCD conversion plus a free-running digit scan
// with optional leading-zero blanking.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV      = 100_000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  fnd_scan_ctrl_if.slave  bus
);

  localparam int PRESC_W = $clog2(SCAN_DIV);

  logic [PRESC_W-1:0] presc_r;
  logic [1:0]         index_r;
  logic [BCD_W-1:0]   display_r;
  logic [1:0]         sel_r;
  logic [3:0]         bcd_r;
  logic               en_r;

  logic               conv_busy_s, conv_done_s, conv_ovf_s;
  logic [BCD_W-1:0]   conv_result_s;
  logic               wrap_s, lead_zero_s, en_s;
  logic [3:0]         digit_s;

  bin2bcd_seq u_conv (
    .clk      (i_clk),
    .rst_n    (i_reset_n),
    .start    (bus.i_load),
    .value    (bus.i_value),
    .busy     (conv_busy_s),
    .done     (conv_done_s),
    .overflow (conv_ovf_s),
    .result   (conv_result_s)
  );

  always_comb begin
    wrap_s      = (presc_r == PRESC_W'(SCAN_DIV - 1));
    digit_s     = display_r[{index_r, 2'b00} +: 4];
    lead_zero_s = ((display_r >> {index_r, 2'b00}) == {BCD_W{1'b0}});
    if ((BLANK_LEADING == 1'b1) && (index_r != 2'd0) && lead_zero_s) begin
      en_s = 1'b0;
    end else begin
      en_s = 1'b1;
    end
  end

  // Free-running prescaler and digit index, independent of the converter.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc_r <= {PRESC_W{1'b0}};
      index_r <= 2'd0;
    end else if (wrap_s) begin
      presc_r <= {PRESC_W{1'b0}};
      index_r <= index_r + 2'd1;
    end else begin
      presc_r <= presc_r + PRESC_W'(1);
      index_r <= index_r;
    end
  end

  // All four digits are replaced together so no slot ever mixes old and new.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      display_r <= {BCD_W{1'b0}};
    end else if (conv_done_s) begin
      display_r <= conv_result_s;
    end else begin
      display_r <= display_r;
    end
  end

  // Output stage: index, digit and enable are registered together so they stay aligned.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sel_r <= 2'd0;
      bcd_r <= 4'd0;
      en_r  <= 1'b0;
    end else begin
      sel_r <= index_r;
      bcd_r <= digit_s;
      en_r  <= en_s;
    end
  end

  assign bus.o_busy        = conv_busy_s;
  assign bus.o_overflow    = conv_ovf_s;
  assign bus.o_digitSelect = sel_r;
  assign bus.o_bcd         = bcd_r;
  assign bus.o_en          = en_r;

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Scan-and-convert front end for the 4-digit FND path. It accepts a binary result of up to 14 bits and converts it to four BCD digits with a sequential double-dabble. It then time-multiplexes those digits, producing the digit-select, 4-bit digit value and enable that drive the BCD-to-FND decoder directly downstream. It replaces the hand-driven digit select and is the block the calculator top uses to light all four digits continuously.

## Interface
- SCAN_DIV, 100_000, clock cycles each digit stays selected (1 kHz digit rate at 100 MHz); legal range ≥ 2.
- BLANK_LEADING, 1, 1 = suppress leading zeros on digits 3..1; digit 0 is never blanked.
- i_clk  input  1  system clock; one clock domain. Reset is asynchronous and active-low.
- i_reset_n  input  1  asynchronous active-low reset.
- i_value  input  14  unsigned binary value to display; sampled on an accepted load.
- i_load  input  1  load strobe; accepted only when o_busy = 0.
- o_busy  output  1  high while a conversion is in progress.
- o_overflow  output  1  sticky; set when the accepted value is > 9999, cleared by the next accepted load.
- o_digitSelect  output  2  current digit index, 0 = ones … 3 = thousands.
- o_bcd  output  4  BCD digit for the current index, range 0..9.
- o_en  output  1  digit enable to the decoder; 0 = blank.

## Operation
- FSM states: IDLE, CONVERT, COMMIT.
  - IDLE: if i_load = 1, capture min(i_value, 9999) into the shift register, clear the BCD accumulator, update o_overflow, and go to CONVERT.
  - CONVERT: one double-dabble iteration per cycle. Add 3 to each BCD nibble ≥ 5, then shift left by 1. Exactly 14 iterations, then go to COMMIT.
  - COMMIT: copy the 16-bit accumulator into the display register in one cycle (atomic update of all 4 digits), then return to IDLE.
- i_load while o_busy = 1 is ignored; it is neither queued nor counted.
- Scan prescaler runs freely, counting 0..SCAN_DIV-1. On wrap the digit index advances 0→1→2→3→0. Scan never stops and is independent of the FSM.
- o_bcd = display[index]. o_en = 0 only when BLANK_LEADING = 1, index ≠ 0, and this digit and all higher digits are zero. Otherwise o_en = 1.
- Arithmetic: a 30-bit combined shift register (16 BCD + 14 binary). Nibble adjust happens before the shift, within the same cycle. The result is always valid BCD because the input is saturated to 9999.

## Timing
- All outputs are registered.
- Reset values:
  - o_busy = 0, o_overflow = 0, o_digitSelect = 0, o_bcd = 0, o_en = 0.
  - Display register = 0, prescaler = 0, state = IDLE.
- First clock after reset release: o_en = 1, o_bcd = 0, so "0" is shown on digit 0.
- Conversion latency, with load accepted at edge N:
  - o_busy = 1 from after edge N through the COMMIT cycle, i.e. 15 cycles.
  - New digits appear on o_bcd from after edge N+16.
  - A new load is accepted at edge N+16 at the earliest.
- Each digit index is held for exactly SCAN_DIV cycles. A full refresh takes 4·SCAN_DIV cycles.
- If COMMIT coincides with a prescaler wrap, the index advance and the display update both take effect on the same edge. The output shows the new value at the new index, with no mixed old/new digits within one index slot.
- Reset asserted mid-conversion aborts immediately. All state returns to reset values and the display shows 0 after release.

## Structure
- Shared package fnd_pkg holds:
  - state enum {IDLE, CONVERT, COMMIT};
  - NUM_DIGITS = 4;
  - MAX_VALUE = 9999;
  - BIN_W = 14;
  - the ITER count (= BIN_W).
- One sub-module, bin2bcd_seq, contains the FSM, the double-dabble datapath, saturation and overflow logic. Its handshake is start/busy/done plus a 16-bit BCD result.
- The top, fnd_scan_ctrl, owns the prescaler, digit index, display register and blanking logic.

## Test plan
All scenarios use SCAN_DIV = 4.
- Reset, no load → o_en = 0 during reset. After release: index cycles 0,1,2,3 every 4 cycles; o_bcd = 0 throughout; o_en = 1 only at index 0.
- Load 1234 → o_busy high for 15 cycles. Digits 4,3,2,1 at indices 0..3 after 16 cycles; o_en = 1 on all four; o_overflow = 0.
- Load 16383 → displays 9,9,9,9 and o_overflow = 1. A subsequent load of 7 clears o_overflow; index 0 shows 7, indices 1..3 have o_en = 0.
- Load 1005 → digits 5,0,0,1 with o_en = 1 on all four (interior zeros not blanked). Rerun with BLANK_LEADING = 0 and value 5: all four enabled, showing 5,0,0,0.
- i_load pulsed again 3 cycles after an accepted load of 42, with value 99 → ignored. Display shows 42 and o_busy drops 15 cycles after the first load.
- Reset asserted at CONVERT iteration 7 of a 9999 load → after release the display shows 0, o_busy = 0, index = 0; the next load of 8 converts normally.
